// File: rtl/vram_scanout.sv
// Display-side VRAM reader: raster counters, one word fetch per WORD_WIDTH pixels,
// MSB-first serialiser, and sync/active/pixel outputs on a common 2-clock pipeline.
module vram_scanout #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int H_ACTIVE   = 128,
  parameter int H_FRONT    = 8,
  parameter int H_SYNC     = 16,
  parameter int H_BACK     = 8,
  parameter int V_ACTIVE   = 128,
  parameter int V_FRONT    = 2,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  blank,
  output logic                  vram_rd_en,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  input  logic [WORD_WIDTH-1:0] vram_data,
  output logic                  pixel,
  output logic                  active,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int WSH     = $clog2(WORD_WIDTH);

  localparam logic [HW-1:0]         H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]         H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0]         HS_BEG  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0]         HS_END  = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0]         V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]         V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0]         VS_BEG  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0]         VS_END  = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [ADDR_WIDTH-1:0] WPL_A   = ADDR_WIDTH'(H_ACTIVE / WORD_WIDTH);

  logic [HW-1:0]         h_r, h_nxt_s;
  logic [VW-1:0]         v_r, v_nxt_s;
  logic                  run_r;
  logic                  blank_r, blank_nxt_s;
  logic                  h_wrap_s, frame_top_s, fetch_s;
  logic                  rd_d1_r;
  logic [ADDR_WIDTH-1:0] line_base_r, line_base_nxt_s;
  logic [WORD_WIDTH-1:0] shift_r, shift_nxt_s;
  logic                  act_d1_r, hs_d1_r, vs_d1_r, fs_d1_r;

  // Next raster position, frame-level blank, line base, fetch decode and shifter input.
  always_comb begin
    h_nxt_s         = h_r;
    v_nxt_s         = v_r;
    line_base_nxt_s = line_base_r;
    h_wrap_s        = run_r && (h_r == H_LAST);
    // run_r is low only on the first clock after reset: the raster holds at the
    // origin so that clock issues the fetch for h=0, v=0.
    if (!run_r) begin
      h_nxt_s = h_r;
      v_nxt_s = v_r;
    end else if (h_wrap_s) begin
      h_nxt_s = {HW{1'b0}};
      v_nxt_s = (v_r == V_LAST) ? {VW{1'b0}} : v_r + VW'(1);
    end else begin
      h_nxt_s = h_r + HW'(1);
      v_nxt_s = v_r;
    end
    frame_top_s = (h_nxt_s == {HW{1'b0}}) && (v_nxt_s == {VW{1'b0}});
    blank_nxt_s = frame_top_s ? blank : blank_r;
    if (frame_top_s) begin
      line_base_nxt_s = {ADDR_WIDTH{1'b0}};
    end else if (h_wrap_s && (v_r < V_ACT)) begin
      line_base_nxt_s = line_base_r + WPL_A;
    end else begin
      line_base_nxt_s = line_base_r;
    end
    fetch_s = (v_nxt_s < V_ACT) && (h_nxt_s < H_ACT) &&
              (h_nxt_s[WSH-1:0] == {WSH{1'b0}}) && !blank_nxt_s;
    shift_nxt_s = rd_d1_r ? vram_data : {shift_r[WORD_WIDTH-2:0], 1'b0};
  end

  // Raster counters, latched blank, line base and registered read strobe/address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_r       <= 1'b0;
      h_r         <= {HW{1'b0}};
      v_r         <= {VW{1'b0}};
      blank_r     <= 1'b0;
      line_base_r <= {ADDR_WIDTH{1'b0}};
      vram_rd_en  <= 1'b0;
      vram_addr   <= {ADDR_WIDTH{1'b0}};
    end else begin
      run_r       <= 1'b1;
      h_r         <= h_nxt_s;
      v_r         <= v_nxt_s;
      blank_r     <= blank_nxt_s;
      line_base_r <= line_base_nxt_s;
      vram_rd_en  <= fetch_s;
      if (fetch_s) begin
        vram_addr <= line_base_nxt_s + ADDR_WIDTH'(h_nxt_s >> WSH);
      end else begin
        vram_addr <= vram_addr;
      end
    end
  end

  // Serialiser and the two-stage output pipeline that keeps all outputs aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_d1_r     <= 1'b0;
      shift_r     <= {WORD_WIDTH{1'b0}};
      act_d1_r    <= 1'b0;
      hs_d1_r     <= 1'b0;
      vs_d1_r     <= 1'b0;
      fs_d1_r     <= 1'b0;
      pixel       <= 1'b0;
      active      <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Read data is valid the clock after the strobe, so the load lines up here.
      rd_d1_r     <= vram_rd_en;
      shift_r     <= shift_nxt_s;
      act_d1_r    <= run_r && (h_r < H_ACT) && (v_r < V_ACT);
      hs_d1_r     <= run_r && (h_r >= HS_BEG) && (h_r < HS_END);
      vs_d1_r     <= run_r && (v_r >= VS_BEG) && (v_r < VS_END);
      fs_d1_r     <= run_r && (h_r == {HW{1'b0}}) && (v_r == {VW{1'b0}});
      pixel       <= shift_nxt_s[WORD_WIDTH-1] && act_d1_r && !blank_r;
      active      <= act_d1_r;
      hsync       <= hs_d1_r;
      vsync       <= vs_d1_r;
      frame_start <= fs_d1_r;
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Directed bench for vram_scanout: reset, pixel order, addressing, sync timing,
// frame-latched blank and mid-frame reset, against a synchronous VRAM model.
module tb_vram_scanout;

  localparam int HT = 160;
  localparam int VT = 136;

  logic        clk;
  logic        reset;
  logic        blank;
  logic        vram_rd_en;
  logic [9:0]  vram_addr;
  logic [15:0] vram_data;
  logic        pixel, active, hsync, vsync, frame_start;

  logic [15:0] mem [0:1023];

  int n_vec = 0;
  int n_bad = 0;

  // raster position of the current sample, as tracked by the bench
  int hh, vv;
  bit started;

  int strobes, addr_bad, exp_idx, last_addr, last_h, last_v, line1_addr;
  int hs_cnt, hs_l5, hs_first5, hs_last5, vs_cnt, act_cnt, act_l5, act_late;
  int fs_cnt, pix_out, pix_ones, pix_bad, act_bad, hs_bad;
  logic [31:0] pixseq;

  vram_scanout dut (
    .clk         (clk),
    .reset       (reset),
    .blank       (blank),
    .vram_rd_en  (vram_rd_en),
    .vram_addr   (vram_addr),
    .vram_data   (vram_data),
    .pixel       (pixel),
    .active      (active),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous VRAM read port, one clock of latency; filler otherwise
  always @(posedge clk) begin
    if (vram_rd_en) vram_data <= mem[vram_addr];
    else            vram_data <= 16'h5A5A;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (h=%0d v=%0d)", tag, got, exp, hh, vv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!started) begin
      started = 1'b1;
      hh = 0;
      vv = 0;
    end else begin
      hh++;
      if (hh == HT) begin
        hh = 0;
        vv++;
        if (vv == VT) vv = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_rd_en"}, {31'd0, vram_rd_en}, 32'd0);
    check_val({pfx, "_addr"},  {22'd0, vram_addr},  32'd0);
    check_val({pfx, "_pixel"}, {31'd0, pixel},      32'd0);
    check_val({pfx, "_active"},{31'd0, active},     32'd0);
    check_val({pfx, "_hsync"}, {31'd0, hsync},      32'd0);
    check_val({pfx, "_vsync"}, {31'd0, vsync},      32'd0);
    check_val({pfx, "_fs"},    {31'd0, frame_start},32'd0);
  endtask

  // Walk the raster from the current (0,0) sample, accumulating statistics,
  // until a full frame has passed or (stop_h, stop_v) is reached.
  task automatic scan_frame(input int fid, input bit blank_frame, input int stop_h, input int stop_v);
    logic [15:0] w;
    bit exp_act, exp_pix, exp_hs;
    int sh;
    strobes = 0; addr_bad = 0; exp_idx = 0; last_addr = -1; last_h = -1; last_v = -1;
    line1_addr = -1; hs_cnt = 0; hs_l5 = 0; hs_first5 = -1; hs_last5 = -1; vs_cnt = 0;
    act_cnt = 0; act_l5 = 0; act_late = 0; fs_cnt = 0; pix_out = 0; pix_ones = 0;
    pix_bad = 0; act_bad = 0; hs_bad = 0; pixseq = 32'd0;
    for (int i = 0; i < HT * VT; i++) begin
      if (hh == stop_h && vv == stop_v) break;
      if (hh == 0 && vv == 0) begin
        check_val($sformatf("rd_top_f%0d", fid), {31'd0, vram_rd_en}, {31'd0, !blank_frame});
        if (!blank_frame) check_val($sformatf("addr_top_f%0d", fid), {22'd0, vram_addr}, 32'd0);
      end
      if (vv == 0 && hh <= 3)
        check_val($sformatf("fs_h%0d_f%0d", hh, fid), {31'd0, frame_start}, {31'd0, hh == 2});
      if (vv == 130 && (hh == 1 || hh == 2))
        check_val($sformatf("vs_in_h%0d", hh), {31'd0, vsync}, {31'd0, hh == 2});
      if (vv == 132 && (hh == 1 || hh == 2))
        check_val($sformatf("vs_out_h%0d", hh), {31'd0, vsync}, {31'd0, hh == 1});
      if (vram_rd_en) begin
        strobes++;
        if (vram_addr != exp_idx[9:0]) addr_bad++;
        exp_idx++;
        last_addr = vram_addr; last_h = hh; last_v = vv;
        if (hh == 0 && vv == 1) line1_addr = vram_addr;
      end
      exp_hs = (hh >= 138 && hh <= 153);
      if (hsync != exp_hs) hs_bad++;
      if (hsync) begin
        hs_cnt++;
        if (vv == 5) begin
          hs_l5++;
          if (hs_first5 < 0) hs_first5 = hh;
          hs_last5 = hh;
        end
      end
      if (vsync) vs_cnt++;
      if (frame_start) fs_cnt++;
      exp_act = (hh >= 2 && hh < 130 && vv < 128);
      if (active != exp_act) act_bad++;
      if (active) begin
        act_cnt++;
        if (vv >= 128) act_late++;
        if (vv == 5) act_l5++;
      end
      exp_pix = 1'b0;
      if (exp_act && !blank_frame) begin
        sh = hh - 2;
        w = mem[vv * 8 + sh / 16];
        exp_pix = w[15 - sh % 16];
      end
      if (pixel != exp_pix) pix_bad++;
      if (pixel) pix_ones++;
      if (pixel && !active) pix_out++;
      if (vv == 0 && hh >= 2 && hh <= 33) pixseq[33 - hh] = pixel;
      if (fid == 0 && hh == 0 && vv == 40) blank = 1'b1;
      if (fid == 1 && hh == 0 && vv == 40) blank = 1'b0;
      step();
    end
  endtask

  initial begin
    reset   = 1'b1;
    blank   = 1'b0;
    started = 1'b0;
    hh = 0;
    vv = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 40503) ^ 16'h5A3C;
    mem[0] = 16'h8001;
    mem[1] = 16'hFFFF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");

    reset = 1'b0;
    step();

    // frame A: normal frame, blank raised at v=40 takes effect next frame
    scan_frame(0, 1'b0, -1, -1);
    check_val("a_pixseq",   pixseq, 32'h8001FFFF);
    check_val("a_line1",    line1_addr, 32'd8);
    check_val("a_strobes",  strobes, 32'd1024);
    check_val("a_addr_seq", addr_bad, 32'd0);
    check_val("a_last_addr",last_addr, 32'd1023);
    check_val("a_last_h",   last_h, 32'd112);
    check_val("a_last_v",   last_v, 32'd127);
    check_val("a_hs_l5",    hs_l5, 32'd16);
    check_val("a_hs_first", hs_first5, 32'd138);
    check_val("a_hs_last",  hs_last5, 32'd153);
    check_val("a_hs_bad",   hs_bad, 32'd0);
    check_val("a_act_l5",   act_l5, 32'd128);
    check_val("a_act_late", act_late, 32'd0);
    check_val("a_act_bad",  act_bad, 32'd0);
    check_val("a_vs_cnt",   vs_cnt, 32'd320);
    check_val("a_fs_cnt",   fs_cnt, 32'd1);
    check_val("a_pix_out",  pix_out, 32'd0);
    check_val("a_pix_bad",  pix_bad, 32'd0);

    // frame B: blanked; timing intact, no fetches, dark pixels
    scan_frame(1, 1'b1, -1, -1);
    check_val("b_strobes",  strobes, 32'd0);
    check_val("b_pix_ones", pix_ones, 32'd0);
    check_val("b_hs_cnt",   hs_cnt, 32'd2176);
    check_val("b_vs_cnt",   vs_cnt, 32'd320);
    check_val("b_act_cnt",  act_cnt, 32'd16384);
    check_val("b_fs_cnt",   fs_cnt, 32'd1);

    // frame C: fetching resumes at address 0; interrupted at h=50, v=60
    scan_frame(2, 1'b0, 50, 60);
    check_val("c_strobes",  strobes, 32'd484);
    check_val("c_addr_seq", addr_bad, 32'd0);
    check_val("c_pix_bad",  pix_bad, 32'd0);
    check_val("c_act_bad",  act_bad, 32'd0);
    check_val("c_pre_addr", {22'd0, vram_addr}, 32'd483);
    check_val("c_pre_act",  {31'd0, active}, 32'd1);

    #2 reset = 1'b1;
    #1 check_all_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    started = 1'b0;
    step();

    // frame D: raster restarts from the origin after the mid-frame reset
    scan_frame(3, 1'b0, 40, 1);
    check_val("d_pixseq",  pixseq, 32'h8001FFFF);
    check_val("d_line1",   line1_addr, 32'd8);
    check_val("d_pix_bad", pix_bad, 32'd0);
    check_val("d_fs_cnt",  fs_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
